// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM-to-WB stage bus: memory-stage results in, register-file write port out
interface mem_wb_stage_if #(
    parameter int XLEN = 32
);
    logic                   in_valid;
    logic                   in_reg_write;
    logic [4:0]             in_rd;
    logic [1:0]             in_wb_sel;
    logic [2:0]             in_funct3;
    logic [1:0]             in_addr_lo;
    logic [XLEN-1:0]        in_alu_result;
    logic [XLEN-1:0]        in_mem_rdata;
    logic [XLEN-1:0]        in_pc_plus4;
    logic [XLEN-1:0]        in_imm;
    logic                   reg_write;
    logic [4:0]             reg_id_w;
    logic signed [XLEN-1:0] write_data;
    logic                   wb_valid;
    logic                   load_misalign;

    modport master (
        output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_mem_rdata, in_pc_plus4, in_imm,
        input  reg_write, reg_id_w, write_data, wb_valid, load_misalign
    );

    modport slave (
        input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_mem_rdata, in_pc_plus4, in_imm,
        output reg_write, reg_id_w, write_data, wb_valid, load_misalign
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB register with load formatting; WB_RETIRE_CNT_EN adds a 64-bit retire counter
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]       retire_cnt,
`endif
    mem_wb_stage_if.slave     bus
);
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            misalign;

    logic            valid_d, valid_q;
    logic            reg_write_d, reg_write_q;
    logic [4:0]      rd_d, rd_q;
    logic [XLEN-1:0] data_d, data_q;
    logic            misalign_d, misalign_q;

    always_comb begin
        sel_byte = bus.in_mem_rdata[8*bus.in_addr_lo +: 8];
        sel_half = bus.in_addr_lo[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];
        load_data = bus.in_mem_rdata;
        case (bus.in_funct3)
            F3_LB:   load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
            F3_LH:   load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, sel_half};
            default: load_data = bus.in_mem_rdata;
        endcase
    end

    always_comb begin
        misalign = bus.in_valid && (bus.in_wb_sel == 2'b01) &&
                   ((((bus.in_funct3 == F3_LH) || (bus.in_funct3 == F3_LHU)) && bus.in_addr_lo[0]) ||
                    ((bus.in_funct3 == F3_LW) && (bus.in_addr_lo != 2'b00)));
        case (bus.in_wb_sel)
            2'b00:   wb_data = bus.in_alu_result;
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = bus.in_pc_plus4;
            default: wb_data = bus.in_imm;
        endcase
    end

    // Invalid instructions load as a bubble so waves stay deterministic.
    always_comb begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        rd_d        = 5'd0;
        data_d      = '0;
        misalign_d  = 1'b0;
        if (bus.in_valid) begin
            valid_d     = 1'b1;
            rd_d        = bus.in_rd;
            misalign_d  = misalign;
            reg_write_d = bus.in_reg_write && (bus.in_rd != 5'd0) && !misalign;
            data_d      = misalign ? '0 : wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            data_q      <= '0;
            misalign_q  <= 1'b0;
        end else if (!stall_i) begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            misalign_q  <= misalign_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_d, retire_cnt_q;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (!flush_i && !stall_i && bus.in_valid && !misalign)
            retire_cnt_d = retire_cnt_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            retire_cnt_q <= 64'd0;
        else
            retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

    assign bus.wb_valid      = valid_q;
    assign bus.reg_write     = reg_write_q;
    assign bus.reg_id_w      = rd_q;
    assign bus.write_data    = data_q;
    assign bus.load_misalign = misalign_q;
endmodule
